lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL expose `rst_n`, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL expose `req`, input, 1 bit: access request, sampled only in IDLE.
REQ-004 The block SHALL expose `store`, input, 1 bit: 1 = store, 0 = load.
REQ-005 The block SHALL expose `funct3`, input, 3 bits: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 The block SHALL expose `addr`, input, 32 bits: byte address.
REQ-007 The block SHALL expose `wdata`, input, 32 bits: store data, right-aligned.
REQ-008 The block SHALL expose `busy`, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL expose `done`, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL expose `err`, output, 1 bit: valid with `done`; access rejected.
REQ-011 The block SHALL expose `rdata`, output, 32 bits: extended load result, held until the next load completes.
REQ-012 The block SHALL expose `mem_addr`, output, 32 bits: word index to data memory, equal to `{2'b00, addr_q[31:2]}`.
REQ-013 The block SHALL expose `mem_wd`, output, 32 bits: full word write data.
REQ-014 The block SHALL expose `mem_we`, output, 1 bit: memory write enable; memory writes on the same `clk` edge.
REQ-015 The block SHALL expose `mem_rd`, input, 32 bits: combinational memory read of `mem_addr`.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, MERGE, WRITE, RESP.
REQ-017 In IDLE with `req`=1, the block SHALL register `addr`, `funct3`, `wdata` and `store`, then transition as follows:
- Load: go to LOAD.
- Store with `funct3`=010: go to WRITE.
- Store with `funct3` 000/001: go to MERGE.
- Rejected access: go to RESP.
REQ-018 The following SHALL be rejected with `err`=1: a load with `funct3` 011/110/111; a store with `funct3` other than 000/001/010.
REQ-019 LOAD SHALL select the byte/halfword of `mem_rd` by `addr_q[1:0]`/`addr_q[1]`, sign-extend (B, H) or zero-extend (BU, HU), register the result into `rdata`, and go to RESP.
REQ-020 MERGE SHALL replace the addressed byte/halfword of `mem_rd` with `wdata_q[7:0]`/`[15:0]`, register the merged word, and go to WRITE.
REQ-021 WRITE SHALL assert `mem_we`=1 for exactly one cycle. `mem_wd` SHALL be the merged word (SB/SH) or `wdata_q` (SW). WRITE then goes to RESP.
REQ-022 RESP SHALL assert `done`=1 for one cycle and then go to IDLE.
REQ-023 Latency from the `req` edge to `done` high SHALL be:
- Load: 2 cycles.
- SW: 2 cycles.
- SB/SH: 3 cycles.
- Rejected access: 1 cycle.
REQ-024 `req` SHALL be ignored while `busy`=1. Back-to-back accesses SHALL be possible with `req` presented in the first IDLE cycle after RESP.
REQ-025 `mem_we` SHALL be 0 in every state except WRITE. A rejected access SHALL never write memory.
REQ-026 Stores SHALL never modify `rdata`.

Reset
REQ-027 With `rst_n`=0 at a rising edge, the block SHALL enter IDLE and clear `rdata`, `err` and the internal registers to 0, so `done`=0 and `busy`=0.
REQ-028 `mem_we` SHALL be gated by `rst_n`. A reset asserted during WRITE SHALL suppress that write, and a reset in MERGE SHALL abort the store with no write.

Configuration
REQ-029 Macro `LSU_MISALIGN_CHECK_EN` defined: H/HU/SH with `addr[0]`=1, or W/SW with `addr[1:0]`≠0, SHALL be rejected (`err`=1, 1-cycle latency, no memory access).
REQ-030 Macro `LSU_MISALIGN_CHECK_EN` undefined: offending low address bits SHALL be forced to 0 (access aligned down), and misalignment SHALL never raise `err`. Illegal `funct3` SHALL still raise `err`.

Verification
REQ-031 Word 2 = 32'h8000_00F0. LB at addr 8 → `rdata`=32'hFFFF_FFF0, `done` 2 cycles after `req`.
REQ-032 Word 2 = 32'h8000_00F0. LHU at addr 10 → `rdata`=32'h0000_8000. LH at addr 10 → `rdata`=32'hFFFF_8000.
REQ-033 Word 1 = 32'h1122_3344. SB `wdata`=32'hAB at addr 6 → word 1 = 32'h11AB_3344, exactly one `mem_we` pulse, `done` 3 cycles after `req`.
REQ-034 SW 32'hDEAD_BEEF at addr 12, then LW at addr 12 issued the cycle after `done` → `rdata`=32'hDEAD_BEEF.
REQ-035 LW at addr 5:
- With `LSU_MISALIGN_CHECK_EN`: `err`=1 and `done` 1 cycle later, no `mem_we`.
- Without it: reads word 1, `err`=0.
REQ-036 SH issued, `rst_n` driven 0 during the MERGE cycle → no `mem_we`, memory unchanged, block in IDLE with `busy`=0 after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: sub-word loads with sign/zero extension and read-modify-write sub-word stores.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses instead of aligning them down.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMerge,
        StWrite,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        store_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] merged_q;

    logic        legal;
    logic        is_half;
    logic        is_word;
    logic        reject;
    logic [31:0] addr_al;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] merged_d;

    // Request decode: legality and (optional) alignment handling.
    always_comb begin
        is_half = (funct3[1:0] == 2'b01);
        is_word = (funct3 == 3'b010);
        legal   = 1'b0;
        if (store) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        end
        addr_al = addr;
`ifdef LSU_MISALIGN_CHECK_EN
        reject = !legal || (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
        reject = !legal;
        if (is_half) addr_al[0] = 1'b0;
        if (is_word) addr_al[1:0] = 2'b00;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (reject)                 state_d = StResp;
                    else if (!store)            state_d = StLoad;
                    else if (funct3 == 3'b010)  state_d = StWrite;
                    else                        state_d = StMerge;
                end
            end
            StLoad:  state_d = StResp;
            StMerge: state_d = StWrite;
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        ld_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = mem_rd;
        endcase
    end

    // Store lane merge into the current memory word.
    always_comb begin
        merged_d = mem_rd;
        if (funct3_q[0]) begin
            if (addr_q[1]) merged_d[31:16] = wdata_q[15:0];
            else           merged_d[15:0]  = wdata_q[15:0];
        end else begin
            merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            funct3_q <= 3'h0;
            wdata_q  <= 32'h0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            merged_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                addr_q   <= addr_al;
                funct3_q <= funct3;
                wdata_q  <= wdata;
                store_q  <= store;
                err_q    <= reject;
            end
            if (state_q == StLoad && !store_q) rdata_q <= load_data;
            if (state_q == StMerge) merged_q <= merged_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StResp);
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign mem_addr = {2'b00, addr_q[31:2]};
    assign mem_wd   = (funct3_q == 3'b010) ? wdata_q : merged_q;
    // Gated by reset so a reset landing in WRITE suppresses the write on that edge.
    assign mem_we   = (state_q == StWrite) && store_q && rst_n;

endmodule
